// File: rtl/reg_file_scoreboard.sv
// Parametrised register file with optional write-to-read bypass, optional
// hardwired-zero register, and per-register pending bits for RAW hazard detection.
module reg_file_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  output logic [DATA_WIDTH-1:0] read_out1,
  output logic [DATA_WIDTH-1:0] read_out2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_reg,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pending;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_wr_en;
  logic                  w_rsv_en;
  logic                  w_byp1;
  logic                  w_byp2;
  logic [NUM_REGS-1:0]   w_pend_next;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign w_wr_en  = reg_write && !(ZERO_REG != 0 && write_reg == '0);
  assign w_rsv_en = rsv_valid && !(ZERO_REG != 0 && rsv_reg == '0);

  assign w_byp1 = (BYPASS != 0) && reg_write && (write_reg == read1);
  assign w_byp2 = (BYPASS != 0) && reg_write && (write_reg == read2);

  always_comb begin
    read_out1 = r_regs[read1];
    if (w_byp1 && w_wr_en) read_out1 = write_data;
    if (ZERO_REG != 0 && read1 == '0) read_out1 = '0;
  end

  always_comb begin
    read_out2 = r_regs[read2];
    if (w_byp2 && w_wr_en) read_out2 = write_data;
    if (ZERO_REG != 0 && read2 == '0) read_out2 = '0;
  end

  assign hazard1 = r_pending[read1] && !w_byp1;
  assign hazard2 = r_pending[read2] && !w_byp2;

  // Set is applied after clear so a new producer issuing as the old one retires stays pending.
  always_comb begin
    w_pend_next = r_pending;
    if (reg_write) w_pend_next[write_reg] = 1'b0;
    if (w_rsv_en)  w_pend_next[rsv_reg]   = 1'b1;
    w_count_next = ($bits(w_count_next))'($countones(w_pend_next));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs    <= '{default: '0};
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (w_wr_en) r_regs[write_reg] <= write_data;
      r_pending <= w_pend_next;
      r_count   <= w_count_next;
    end
  end

  assign pending_count = r_count;

endmodule
